vend_stock_ctrl: RTL and testbench
==================================

Name: vend_stock_ctrl

Overview:
Transaction and inventory controller for the vending-machine front panel. Debounces the panel buttons, tracks the selected item, the inserted credit and a 4-bit stock count per item. Runs the purchase, refund and restock sequence. Sits directly upstream of the seven-segment display driver, which consumes quant (0..15) and item_idx.

Parameters:
N_ITEMS, 4, number of items; item_idx width is 2.
INIT_STOCK, 10, stock loaded into every item on reset (0..15).
DB_CYCLES, 100000, clk cycles a button must be stable before it is accepted; benches override to 4.

Ports:
clk  in  1  system clock
rst  in  1  reset
btn_sel  in  1  raw button: select next item
btn_coin  in  1  raw button: insert one coin
btn_buy  in  1  raw button: purchase selected item
btn_cancel  in  1  raw button: abort and refund
btn_restock  in  1  raw button: add one unit to selected item
item_idx  out  2  currently selected item
quant  out  4  stock of selected item (display input)
credit  out  4  coins inserted, saturating at 15
dispense  out  1  one-cycle pulse: item released
refund  out  1  one-cycle pulse: coins returned
refund_amt  out  4  coins returned; valid while refund=1, else 0
err_empty  out  1  one-cycle pulse: buy on empty stock
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset is rst, asynchronous, active-low; clock is clk. All logic is clocked on posedge clk.
- Reset values: stock[*]=INIT_STOCK, item_idx=0, quant=INIT_STOCK, credit=0, dispense=0, refund=0, refund_amt=0, err_empty=0, state=IDLE.
- A reset mid-transaction drops the credit without a refund pulse.
- Each button path is a 2-flop synchroniser, then a counter that accepts the new level after DB_CYCLES consecutive equal samples, then a rising-edge detector.
- Each button produces one 1-cycle event per press. Holding a button produces no repeat events.
- If several events arrive in the same cycle, only the highest-priority event is acted on and the rest are discarded. Priority: cancel > buy > coin > sel > restock.
- Prices are fixed constants: item0=2, item1=3, item2=5, item3=7 coins.
- FSM states: IDLE=0, PAY=1, DISPENSE=2, REFUND=3.
- IDLE:
  - sel: item_idx+1, wrapping from 3 to 0.
  - restock: stock[item_idx]+1, saturating at 15 (no wrap).
  - coin: credit=1, go to PAY.
  - buy and cancel are ignored.
- PAY:
  - coin: credit+1, saturating at 15. Excess coins are swallowed.
  - buy with stock=0: err_empty pulse, stay in PAY.
  - buy with credit>=price: go to DISPENSE.
  - buy with credit<price: ignored.
  - cancel: go to REFUND.
  - sel and restock are ignored, so the selection is frozen while paying.
- DISPENSE (exactly 1 cycle):
  - stock[item_idx] -1, credit = credit - price, dispense=1.
  - Next state is REFUND if the remaining credit is >0, else IDLE.
  - Any events arriving during this cycle are dropped.
- REFUND (exactly 1 cycle):
  - refund=1, refund_amt=credit, credit cleared to 0, next state IDLE.
  - Events arriving during this cycle are dropped.
- quant is registered from stock[item_idx]. It reflects a change to item_idx or stock one cycle after the update.
- All arithmetic is 4-bit unsigned. The subtraction in DISPENSE cannot underflow, because DISPENSE is only entered with credit>=price.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE/PAY/DISPENSE/REFUND);
  - PRICE constant array indexed by item;
  - MAX_STOCK=15 and MAX_CREDIT=15;
  - event priority encoding.
- One natural sub-module, btn_debounce: parameter DB_CYCLES; ports clk, rst, btn_raw, btn_pulse. It is instantiated 5 times.

Test Plan:
- Reset, then sel pressed twice (DB_CYCLES=4) -> item_idx=2, quant=10, credit=0, all pulses 0.
- Select item1 (price 3), coin x4, buy -> dispense=1 for one cycle; next cycle refund=1 with refund_amt=1; quant 10->9, credit ends 0, state IDLE.
- Select item3 (price 7), coin x2, buy -> no response, state stays PAY; then cancel -> refund=1, refund_amt=2, credit=0.
- Drain item0 to stock 0 by repeated purchases (2 coins each), then coin x2, buy -> err_empty=1, state stays PAY, quant=0. Restock at 15 followed by one more restock -> quant stays 15.
- Press coin and cancel in the same cycle while in PAY with credit=3 -> only the refund occurs, refund_amt=3. Holding btn_coin for 50 cycles -> exactly +1 credit. Coin x20 -> credit saturates at 15.
- Assert rst in PAY with credit=5 -> no refund pulse; credit=0, stock restored to 10, item_idx=0, state IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAY      = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_RESTOCK,
    EV_SEL,
    EV_COIN,
    EV_BUY,
    EV_CANCEL
  } event_t;

  localparam logic [3:0] MAX_STOCK  = 4'd15;
  localparam logic [3:0] MAX_CREDIT = 4'd15;

  localparam logic [3:0] PRICE [4] = '{4'd2, 4'd3, 4'd5, 4'd7};

  // Simultaneous presses collapse to the single highest-priority event.
  function automatic event_t pick_event(input logic cancel, input logic buy,
                                        input logic coin, input logic sel,
                                        input logic restock);
    if (cancel)       return EV_CANCEL;
    else if (buy)     return EV_BUY;
    else if (coin)    return EV_COIN;
    else if (sel)     return EV_SEL;
    else if (restock) return EV_RESTOCK;
    else              return EV_NONE;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // The accepted level only moves after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], btn_raw};
      level_q <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign btn_pulse = level & ~level_q;

endmodule

// File: rtl/vend_stock_ctrl.sv
// Vending transaction and inventory controller: selection, credit, stock, purchase/refund FSM.
module vend_stock_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned N_ITEMS    = 4,
  parameter int unsigned INIT_STOCK = 10,
  parameter int unsigned DB_CYCLES  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_sel,
  input  logic       btn_coin,
  input  logic       btn_buy,
  input  logic       btn_cancel,
  input  logic       btn_restock,
  output logic [1:0] item_idx,
  output logic [3:0] quant,
  output logic [3:0] credit,
  output logic       dispense,
  output logic       refund,
  output logic [3:0] refund_amt,
  output logic       err_empty,
  output logic [1:0] state_o
);

  logic [4:0] raw;
  logic [4:0] pulse;
  assign raw = {btn_cancel, btn_buy, btn_coin, btn_sel, btn_restock};

  for (genvar g = 0; g < 5; g++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (raw[g]),
      .btn_pulse (pulse[g])
    );
  end

  state_t     state, state_n;
  event_t     ev;
  logic [3:0] stock [N_ITEMS];
  logic [3:0] price;
  logic [3:0] sel_stock;
  logic [3:0] credit_left;
  logic       do_sel, do_restock, do_first_coin, do_coin, err_n;

  assign ev          = pick_event(pulse[4], pulse[3], pulse[2], pulse[1], pulse[0]);
  assign price       = PRICE[item_idx];
  assign sel_stock   = stock[item_idx];
  assign credit_left = credit - price;
  assign state_o     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // DISPENSE and REFUND are single-cycle; events seen there are dropped.
  always_comb begin
    state_n       = state;
    do_sel        = 1'b0;
    do_restock    = 1'b0;
    do_first_coin = 1'b0;
    do_coin       = 1'b0;
    err_n         = 1'b0;
    dispense      = 1'b0;
    refund        = 1'b0;
    refund_amt    = '0;
    case (state)
      IDLE: begin
        case (ev)
          EV_SEL:     do_sel = 1'b1;
          EV_RESTOCK: do_restock = 1'b1;
          EV_COIN: begin
            do_first_coin = 1'b1;
            state_n       = PAY;
          end
          default: ;
        endcase
      end
      PAY: begin
        case (ev)
          EV_COIN: do_coin = 1'b1;
          EV_BUY: begin
            if (sel_stock == '0)      err_n   = 1'b1;
            else if (credit >= price) state_n = DISPENSE;
          end
          EV_CANCEL: state_n = REFUND;
          default: ;
        endcase
      end
      DISPENSE: begin
        dispense = 1'b1;
        state_n  = (credit_left != '0) ? REFUND : IDLE;
      end
      REFUND: begin
        refund     = 1'b1;
        refund_amt = credit;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) stock[i] <= 4'(INIT_STOCK);
      item_idx  <= '0;
      credit    <= '0;
      quant     <= 4'(INIT_STOCK);
      err_empty <= 1'b0;
    end else begin
      err_empty <= err_n;
      quant     <= sel_stock;
      if (do_sel) item_idx <= item_idx + 1'b1;
      if (do_restock && sel_stock != MAX_STOCK) stock[item_idx] <= sel_stock + 1'b1;
      if (do_first_coin) credit <= 4'd1;
      if (do_coin && credit != MAX_CREDIT) credit <= credit + 1'b1;
      if (state == DISPENSE) begin
        stock[item_idx] <= sel_stock - 1'b1;
        credit          <= credit_left;
      end
      if (state == REFUND) credit <= '0;
    end
  end

endmodule

// File: tb/tb_vend_stock_ctrl.sv
// Self-checking bench for vend_stock_ctrl: directed table, corner sequences, randomized presses vs model.
module tb_vend_stock_ctrl;

  localparam int B_RESTOCK = 0;
  localparam int B_SEL     = 1;
  localparam int B_COIN    = 2;
  localparam int B_BUY     = 3;
  localparam int B_CANCEL  = 4;
  localparam logic [4:0] M_RST = 5'b00001;
  localparam logic [4:0] M_SEL = 5'b00010;
  localparam logic [4:0] M_CON = 5'b00100;
  localparam logic [4:0] M_BUY = 5'b01000;
  localparam logic [4:0] M_CAN = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_sel = 1'b0, btn_coin = 1'b0, btn_buy = 1'b0;
  logic       btn_cancel = 1'b0, btn_restock = 1'b0;
  logic [1:0] item_idx;
  logic [3:0] quant, credit, refund_amt;
  logic       dispense, refund, err_empty;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  vend_stock_ctrl #(.N_ITEMS(4), .INIT_STOCK(10), .DB_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_sel     (btn_sel),
    .btn_coin    (btn_coin),
    .btn_buy     (btn_buy),
    .btn_cancel  (btn_cancel),
    .btn_restock (btn_restock),
    .item_idx    (item_idx),
    .quant       (quant),
    .credit      (credit),
    .dispense    (dispense),
    .refund      (refund),
    .refund_amt  (refund_amt),
    .err_empty   (err_empty),
    .state_o     (state_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // pulse monitor
  int disp_cnt = 0, ref_cnt = 0, ramt_sum = 0, err_cnt = 0;
  bit bad_amt = 1'b0;
  always @(negedge clk) begin
    if (dispense) disp_cnt++;
    if (refund) begin
      ref_cnt++;
      ramt_sum += int'(refund_amt);
    end
    if (!refund && refund_amt != 4'd0) bad_amt = 1'b1;
    if (err_empty) err_cnt++;
  end

  // reference model: one abstract transaction per press
  int price [4] = '{2, 3, 5, 7};
  int m_stock [4];
  int m_item, m_credit;
  bit m_pay;
  int e_disp, e_ref, e_ramt, e_err;
  int d_disp, d_ref, d_ramt, d_err;

  task model_reset();
    for (int i = 0; i < 4; i++) m_stock[i] = 10;
    m_item = 0; m_credit = 0; m_pay = 1'b0;
  endtask

  task model_apply(input logic [4:0] m);
    int top;
    top = -1;
    for (int b = 0; b < 5; b++) if (m[b]) top = b;
    e_disp = 0; e_ref = 0; e_ramt = 0; e_err = 0;
    if (!m_pay) begin
      if (top == B_SEL) m_item = (m_item + 1) % 4;
      else if (top == B_RESTOCK) begin
        if (m_stock[m_item] < 15) m_stock[m_item]++;
      end else if (top == B_COIN) begin
        m_credit = 1; m_pay = 1'b1;
      end
    end else begin
      if (top == B_COIN) begin
        if (m_credit < 15) m_credit++;
      end else if (top == B_BUY) begin
        if (m_stock[m_item] == 0) e_err = 1;
        else if (m_credit >= price[m_item]) begin
          e_disp = 1;
          m_stock[m_item]--;
          m_credit -= price[m_item];
          if (m_credit > 0) begin e_ref = 1; e_ramt = m_credit; end
          m_credit = 0; m_pay = 1'b0;
        end
      end else if (top == B_CANCEL) begin
        e_ref = 1; e_ramt = m_credit; m_credit = 0; m_pay = 1'b0;
      end
    end
  endtask

  task check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task drive(input logic [4:0] m);
    {btn_cancel, btn_buy, btn_coin, btn_sel, btn_restock} = m;
  endtask

  task press(input logic [4:0] m, input int hold);
    int s_disp, s_ref, s_ramt, s_err;
    s_disp = disp_cnt; s_ref = ref_cnt; s_ramt = ramt_sum; s_err = err_cnt;
    @(negedge clk) drive(m);
    repeat (hold) @(negedge clk);
    drive(5'b0);
    repeat (14) @(negedge clk);
    model_apply(m);
    d_disp = disp_cnt - s_disp; d_ref = ref_cnt - s_ref;
    d_ramt = ramt_sum - s_ramt; d_err = err_cnt - s_err;
  endtask

  task check_model(input string tag);
    check({tag, ".item"},   int'(item_idx), m_item);
    check({tag, ".quant"},  int'(quant), m_stock[m_item]);
    check({tag, ".credit"}, int'(credit), m_credit);
    check({tag, ".state"},  int'(state_o), m_pay ? 1 : 0);
    check({tag, ".disp"},   d_disp, e_disp);
    check({tag, ".refund"}, d_ref, e_ref);
    check({tag, ".ramt"},   d_ramt, e_ramt);
    check({tag, ".err"},    d_err, e_err);
  endtask

  task do_reset();
    @(negedge clk);
    drive(5'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
  endtask

  typedef struct {
    logic [4:0] m;
    int item, quant, credit, st, disp, rf, ramt, err;
  } vec_t;
  vec_t tbl [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl.push_back('{M_SEL, 1, 10, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{M_SEL, 2, 10, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{M_SEL, 3, 10, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{M_SEL, 0, 10, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{M_SEL, 1, 10, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{M_CON, 1, 10, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{M_CON, 1, 10, 2, 1, 0, 0, 0, 0});
    tbl.push_back('{M_CON, 1, 10, 3, 1, 0, 0, 0, 0});
    tbl.push_back('{M_CON, 1, 10, 4, 1, 0, 0, 0, 0});
    tbl.push_back('{M_BUY, 1,  9, 0, 0, 1, 1, 1, 0});
    tbl.push_back('{M_SEL, 2, 10, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{M_SEL, 3, 10, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{M_CON, 3, 10, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{M_CON, 3, 10, 2, 1, 0, 0, 0, 0});
    tbl.push_back('{M_BUY, 3, 10, 2, 1, 0, 0, 0, 0});
    tbl.push_back('{M_SEL, 3, 10, 2, 1, 0, 0, 0, 0});
    tbl.push_back('{M_CAN, 3, 10, 0, 0, 0, 1, 2, 0});
    tbl.push_back('{M_BUY, 3, 10, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{M_CAN, 3, 10, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{M_CON, 3, 10, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{M_CON, 3, 10, 2, 1, 0, 0, 0, 0});
    tbl.push_back('{M_CON, 3, 10, 3, 1, 0, 0, 0, 0});
    tbl.push_back('{M_CON | M_CAN, 3, 10, 0, 0, 0, 1, 3, 0});
    tbl.push_back('{M_RST, 3, 11, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{M_CON | M_SEL, 3, 11, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{M_CAN, 3, 11, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{M_SEL | M_RST, 0, 10, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{M_CON, 0, 10, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{M_BUY | M_CON, 0, 10, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{M_CAN, 0, 10, 0, 0, 0, 1, 1, 0});

    do_reset();
    check("reset.item",   int'(item_idx), 0);
    check("reset.quant",  int'(quant), 10);
    check("reset.credit", int'(credit), 0);
    check("reset.state",  int'(state_o), 0);
    check("reset.pulses", int'({dispense, refund, err_empty}), 0);
    check("reset.ramt",   int'(refund_amt), 0);

    foreach (tbl[i]) begin
      press(tbl[i].m, 12);
      check($sformatf("tbl%0d.item", i),   int'(item_idx), tbl[i].item);
      check($sformatf("tbl%0d.quant", i),  int'(quant), tbl[i].quant);
      check($sformatf("tbl%0d.credit", i), int'(credit), tbl[i].credit);
      check($sformatf("tbl%0d.state", i),  int'(state_o), tbl[i].st);
      check($sformatf("tbl%0d.disp", i),   d_disp, tbl[i].disp);
      check($sformatf("tbl%0d.refund", i), d_ref, tbl[i].rf);
      check($sformatf("tbl%0d.ramt", i),   d_ramt, tbl[i].ramt);
      check($sformatf("tbl%0d.err", i),    d_err, tbl[i].err);
    end

    // dispense then refund on consecutive cycles
    do_reset();
    repeat (4) press(M_CON, 12);
    begin
      int k;
      k = 0;
      @(negedge clk) drive(M_BUY);
      while (!dispense && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("seq.dispense_seen", int'(dispense), 1);
      check("seq.state_dispense", int'(state_o), 2);
      check("seq.refund_during_disp", int'(refund), 0);
      @(negedge clk);
      check("seq.dispense_width", int'(dispense), 0);
      check("seq.refund_next", int'(refund), 1);
      check("seq.refund_amt", int'(refund_amt), 2);
      @(negedge clk);
      check("seq.refund_width", int'(refund), 0);
      check("seq.state_idle", int'(state_o), 0);
      drive(5'b0);
      repeat (14) @(negedge clk);
      model_apply(M_BUY);
      check("seq.quant", int'(quant), 9);
      check("seq.credit", int'(credit), 0);
    end

    // drain item0, then empty-buy error, then restock saturation
    do_reset();
    for (int n = 0; n < 10; n++) begin
      press(M_CON, 12);
      press(M_CON, 12);
      press(M_BUY, 12);
      check_model($sformatf("drain%0d", n));
    end
    press(M_CON, 12);
    press(M_CON, 12);
    press(M_BUY, 12);
    check_model("empty");
    check("empty.err", d_err, 1);
    check("empty.state", int'(state_o), 1);
    check("empty.quant", int'(quant), 0);
    press(M_CAN, 12);
    check_model("empty_cancel");
    for (int n = 0; n < 16; n++) press(M_RST, 12);
    check_model("restock_sat");
    check("restock_sat.quant", int'(quant), 15);

    // held button, coin saturation
    do_reset();
    press(M_CON, 50);
    check_model("hold");
    check("hold.credit", int'(credit), 1);
    for (int n = 0; n < 20; n++) press(M_CON, 12);
    check_model("coin_sat");
    check("coin_sat.credit", int'(credit), 15);
    press(M_CAN, 12);
    check_model("coin_sat_cancel");
    check("coin_sat_cancel.ramt", d_ramt, 15);

    // reset while paying drops credit silently and reloads stock
    do_reset();
    press(M_CON, 12);
    press(M_CON, 12);
    press(M_BUY, 12);
    check("pre_rst.quant", int'(quant), 9);
    repeat (5) press(M_CON, 12);
    check("pre_rst.credit", int'(credit), 5);
    begin
      int s_ref;
      s_ref = ref_cnt;
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("in_rst.credit", int'(credit), 0);
      check("in_rst.state", int'(state_o), 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      model_reset();
      check("post_rst.refunds", ref_cnt - s_ref, 0);
      check("post_rst.credit", int'(credit), 0);
      check("post_rst.quant", int'(quant), 10);
      check("post_rst.item", int'(item_idx), 0);
      check("post_rst.state", int'(state_o), 0);
    end

    // randomized presses against the model
    do_reset();
    for (int n = 0; n < 80; n++) begin
      logic [4:0] m;
      int r;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    m = 5'($urandom_range(1, 31));
        2, 3, 4: m = M_CON;
        5, 9:    m = M_BUY;
        6:       m = M_SEL;
        7:       m = M_RST;
        default: m = M_CAN;
      endcase
      press(m, 12);
      check_model($sformatf("rnd%0d", n));
    end

    check("refund_amt_zero_when_idle", int'(bad_amt), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
